// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, SubBytes FSM states and byte accessors
// for [0:127] state vectors (byte 0 = bits [0:7], MSB-first).
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Read byte idx of a state vector.
    function automatic logic [AES_BYTE_W-1:0] get_byte(input logic [0:AES_BLOCK_W-1] v,
                                                       input int idx);
        return v[idx*AES_BYTE_W +: AES_BYTE_W];
    endfunction

    // Return a copy of v with byte idx replaced by b.
    function automatic logic [0:AES_BLOCK_W-1] set_byte(input logic [0:AES_BLOCK_W-1] v,
                                                        input int idx,
                                                        input logic [AES_BYTE_W-1:0] b);
        logic [0:AES_BLOCK_W-1] r;
        r = v;
        r[idx*AES_BYTE_W +: AES_BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/aes_sub_bytes_iter_if.sv
// Input and output streaming ports of the SubBytes engine.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; a producer holding valid keeps its data stable until that edge, and
// ready may depend combinationally on the consumer's own state.
interface aes_sub_bytes_iter_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [0:AES_BLOCK_W-1] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [0:AES_BLOCK_W-1] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_s_box.sv
// Forward AES S-box (FIPS-197), purely combinational 8-bit lookup.
module aes_s_box
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] sbox_in_i,
    output logic [AES_BYTE_W-1:0] sbox_out_o
);

    // Entry 0 is the leftmost byte of the constant.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sbox_out_o = SBOX[sbox_in_i];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative forward SubBytes: captures one 128-bit state, substitutes LANES
// bytes per cycle over NCYC cycles, then holds the result until retired.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    aes_sub_bytes_iter_if.slave  bus,
    output logic                 busy,
    output aes_state_e           dbg_state_o
);

    localparam int NCYC = AES_NBYTES / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    aes_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic [0:AES_BLOCK_W-1] work_q;
    logic [0:AES_BLOCK_W-1] work_d;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   accept;

    logic [AES_BYTE_W-1:0]  lane_in  [LANES];
    logic [AES_BYTE_W-1:0]  lane_out [LANES];

    // Ready in IDLE, or in DONE when the result leaves on this same edge.
    assign bus.in_ready = !rst && ((state_q == IDLE) ||
                                   ((state_q == DONE) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;
    assign busy          = busy_q;
    assign dbg_state_o   = state_q;

    // Lane j reads byte cnt*LANES+j of the working register.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = get_byte(work_q, (int'(cnt_q) * LANES + j) % AES_NBYTES);
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        aes_s_box u_sbox (
            .sbox_in_i  (lane_in[j]),
            .sbox_out_o (lane_out[j])
        );
    end

    // Working register with the current group of lanes substituted.
    always_comb begin
        work_d = work_q;
        for (int j = 0; j < LANES; j++) begin
            work_d = set_byte(work_d, (int'(cnt_q) * LANES + j) % AES_NBYTES, lane_out[j]);
        end
    end

    // Control FSM with registered out_valid/busy; counter is 0 outside BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q  <= bus.in_data;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == CW'(NCYC - 1)) begin
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            // Retire and capture on the same edge.
                            work_q  <= bus.in_data;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: three instances (LANES = 1, 4, 16) checked
// against a GF(2^8) inverse + affine reference model and FIPS-197 constants.
module tb_aes_sub_bytes_iter;
    import aes_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        int           dut;
        logic [0:127] din;
        logic [0:127] exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid_a  [NDUT];
    logic [0:127] in_data_a   [NDUT];
    logic         out_ready_a [NDUT];
    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [0:127] out_data_w  [NDUT];
    logic         busy_w      [NDUT];
    aes_state_e   dbg_w       [NDUT];

    int checks;
    int errors;

    logic [7:0] sb_m  [256];
    logic [7:0] inv_m [256];

    // Clock and DUT instances
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        aes_sub_bytes_iter_if bus ();
        assign bus.in_valid   = in_valid_a[g];
        assign bus.in_data    = in_data_a[g];
        assign bus.out_ready  = out_ready_a[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign out_data_w[g]  = bus.out_data;
        aes_sub_bytes_iter #(.LANES(L)) dut (
            .clk         (clk),
            .rst         (rst),
            .bus         (bus),
            .busy        (busy_w[g]),
            .dbg_state_o (dbg_w[g])
        );
    end

    function automatic int ncyc_of(input int d);
        int l;
        l = (d == 0) ? 1 : ((d == 1) ? 4 : 16);
        return 16 / l;
    endfunction

    // Reference model: multiplicative inverse in GF(2^8) then the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [0:127] model_block(input logic [0:127] v);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sb_m[v[i*8 +: 8]];
        return r;
    endfunction

    // Scoreboard comparison
    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic start_block(input int d, input logic [0:127] din);
        int guard;
        @(negedge clk);
        in_valid_a[d]  = 1'b1;
        in_data_a[d]   = din;
        out_ready_a[d] = 1'b0;
        guard = 0;
        while (!in_ready_w[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready_w[d]) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready never rose", d);
        end
        @(posedge clk);
        #1;
        in_valid_a[d] = 1'b0;
        in_data_a[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_done(input int d, output int lat, output int busyc);
        lat   = 0;
        busyc = busy_w[d] ? 1 : 0;
        while (!out_valid_w[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy_w[d]) busyc++;
        end
    endtask

    task automatic retire(input int d, input string tag);
        @(negedge clk);
        out_ready_a[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[d] = 1'b0;
        check_val({tag, "_retire"}, 128'(out_valid_w[d]), 128'(0));
    endtask

    task automatic run_block(input int d, input logic [0:127] din, input logic [0:127] exp,
                             input string tag);
        int lat, bc;
        start_block(d, din);
        wait_done(d, lat, bc);
        check_val({tag, "_data"}, out_data_w[d], exp);
        check_val({tag, "_lat"}, 128'(lat), 128'(ncyc_of(d)));
        check_val({tag, "_busy"}, 128'(bc), 128'(ncyc_of(d)));
        retire(d, tag);
    endtask

    // Watchdog
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Main sequence
    initial begin
        vec_t         vq[$];
        vec_t         v;
        logic [0:127] seq, din, hold, blk;
        int           lat, bc, bp_bad, mism;

        checks = 0;
        errors = 0;
        for (int x = 0; x < 256; x++) sb_m[x] = sbox_model(8'(x));
        for (int x = 0; x < 256; x++) inv_m[sb_m[x]] = 8'(x);

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_a[d] = 1'b0; in_data_a[d] = '0; out_ready_a[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check_val($sformatf("rst_in_ready%0d", d), 128'(in_ready_w[d]), 128'(0));
            check_val($sformatf("rst_out_valid%0d", d), 128'(out_valid_w[d]), 128'(0));
            check_val($sformatf("rst_out_data%0d", d), out_data_w[d], 128'(0));
            check_val($sformatf("rst_busy%0d", d), 128'(busy_w[d]), 128'(0));
            check_val($sformatf("rst_state%0d", d), 128'(dbg_w[d]), 128'(IDLE));
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++)
            check_val($sformatf("idle_in_ready%0d", d), 128'(in_ready_w[d]), 128'(1));

        // Vector table
        seq = 128'h000102030405060708090a0b0c0d0e0f;
        vq.push_back('{1, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                          128'hd42711aee0bf98f1b8b45de51e415230});
        for (int d = 0; d < NDUT; d++) begin
            vq.push_back('{d, {16{8'h00}}, {16{8'h63}}});
            vq.push_back('{d, {16{8'h53}}, {16{8'hed}}});
            vq.push_back('{d, {16{8'hff}}, {16{8'h16}}});
            vq.push_back('{d, seq, 128'h637c777bf26b6fc53001672bfed7ab76});
        end
        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            run_block(v.dut, v.din, v.exp, $sformatf("vec%0d_dut%0d", k, v.dut));
        end

        // Random blocks against the model
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 5; k++) begin
                din = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_block(d, din, model_block(din), $sformatf("rnd%0d_dut%0d", k, d));
            end
        end

        // Backpressure on LANES=4
        din = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_block(1, din);
        wait_done(1, lat, bc);
        hold = out_data_w[1];
        check_val("bp_data", hold, model_block(din));
        bp_bad = 0;
        @(negedge clk);
        in_valid_a[1] = 1'b1;
        in_data_a[1]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid_w[1] !== 1'b1 || out_data_w[1] !== hold || in_ready_w[1] !== 1'b0)
                bp_bad++;
        end
        check_val("bp_stable_cycles", 128'(bp_bad), 128'(0));
        in_valid_a[1] = 1'b0;
        retire(1, "bp");
        @(posedge clk);
        #1;
        check_val("bp_single_handshake", 128'(out_valid_w[1]), 128'(0));
        check_val("bp_back_idle", 128'(dbg_w[1]), 128'(IDLE));

        // Simultaneous retire and accept
        for (int d = 0; d < NDUT; d++) begin
            din = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_block(d, din);
            wait_done(d, lat, bc);
            check_val($sformatf("sim_first_dut%0d", d), out_data_w[d], model_block(din));
            @(negedge clk);
            out_ready_a[d] = 1'b1;
            in_valid_a[d]  = 1'b1;
            in_data_a[d]   = seq;
            #1;
            check_val($sformatf("sim_in_ready_dut%0d", d), 128'(in_ready_w[d]), 128'(1));
            @(posedge clk);
            #1;
            out_ready_a[d] = 1'b0;
            in_valid_a[d]  = 1'b0;
            check_val($sformatf("sim_out_valid_dut%0d", d), 128'(out_valid_w[d]), 128'(0));
            check_val($sformatf("sim_busy_dut%0d", d), 128'(busy_w[d]), 128'(1));
            wait_done(d, lat, bc);
            check_val($sformatf("sim_lat_dut%0d", d), 128'(lat), 128'(ncyc_of(d)));
            check_val($sformatf("sim_data_dut%0d", d), out_data_w[d],
                      128'h637c777bf26b6fc53001672bfed7ab76);
            retire(d, $sformatf("sim_dut%0d", d));
        end

        // Reset in the second BUSY cycle
        start_block(1, {$urandom(), $urandom(), $urandom(), $urandom()});
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_out_valid", 128'(out_valid_w[1]), 128'(0));
        check_val("midrst_out_data", out_data_w[1], 128'(0));
        check_val("midrst_busy", 128'(busy_w[1]), 128'(0));
        check_val("midrst_in_ready", 128'(in_ready_w[1]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_ready_after", 128'(in_ready_w[1]), 128'(1));
        run_block(1, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                  128'hd42711aee0bf98f1b8b45de51e415230, "midrst_fresh");

        // Round trip of all 256 byte values through the inverse table
        mism = 0;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) blk[i*8 +: 8] = 8'(k * 16 + i);
            start_block(k % NDUT, blk);
            wait_done(k % NDUT, lat, bc);
            for (int i = 0; i < 16; i++)
                if (inv_m[out_data_w[k % NDUT][i*8 +: 8]] !== blk[i*8 +: 8]) mism++;
            retire(k % NDUT, $sformatf("rt%0d", k));
        end
        check_val("roundtrip_mismatches", 128'(mism), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
Sequential forward SubBytes engine for the AES encryption datapath. It is the encrypt-side counterpart of the inverse S-box used in decryption.
- Accepts one 128-bit state over a valid/ready handshake.
- Substitutes LANES bytes per cycle through LANES forward S-box instances.
- Presents the result on a valid/ready output port.
- Sits between the AddRoundKey stage and ShiftRows in the encryption round loop.

Parameters:
LANES, 4, S-box instances used per cycle; legal values 1, 2, 4, 8, 16 (must divide 16).
NCYC, 16/LANES (derived localparam), number of substitution cycles per block.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept in_data this cycle.
in_data  input  [0:127]  state to substitute; byte i = bits [8i:8i+7]; byte 0 = bits [0:7], MSB-first.
out_valid  output  1  out_data holds a completed substitution.
out_ready  input  1  consumer accepts out_data.
out_data  output  [0:127]  substituted state; same byte order as in_data.
busy  output  1  high in BUSY state.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE, counter = 0, out_valid = 0, out_data = 0.
  - in_ready = 0 while rst is high.
  - Reset mid-operation discards the block in flight; no partial output is ever presented.
- State machine, three states:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_data into the working register, set counter = 0, go to BUSY.
  - BUSY: each cycle, replace bytes [counter*LANES .. counter*LANES+LANES-1] with S(byte). Increment counter. After the cycle where counter = NCYC-1, go to DONE. in_ready = 0.
  - DONE: out_valid = 1; out_data = working register, held stable until accepted.
    - On out_ready with no new input: go to IDLE.
- in_ready is high in IDLE, or in DONE when out_ready is high (combinational from state and out_ready). It is low in BUSY and during reset.
- Simultaneous events in DONE: if out_ready & in_valid in the same cycle, the output is retired and the new input is captured on the same edge; next state is BUSY with counter = 0.
- Latency: if input is accepted at edge E0, out_valid is high after edge E0+NCYC.
  - LANES=4: 4 cycles; LANES=16: 1 cycle.
  - Back-to-back throughput: one block per NCYC+1 cycles.
- out_valid stays high and out_data stays constant under backpressure (out_ready low), for any number of cycles.
- in_data is sampled only at the accepting edge; later changes to in_data have no effect.
- The counter width is ceil(log2(NCYC)), minimum 1 bit. The counter is 0 whenever the block is not in BUSY.
- The S-box is the FIPS-197 forward table, combinational, 8-bit in and 8-bit out. S(x) is the exact inverse of the decryption-side table.
- busy = 1 only in BUSY.

Decomposition:
- Shared package aes_pkg holds:
  - state enum IDLE/BUSY/DONE;
  - AES_BLOCK_W = 128 and AES_BYTE_W = 8;
  - helper functions to get and set byte i of a [0:127] vector.
- Natural sub-module: aes_s_box, the forward 256-entry combinational lookup, 8-bit in/out. It is instantiated LANES times; lane j reads byte counter*LANES+j.
- FSM, counter and working register live in aes_sub_bytes_iter.

Test Plan:
- FIPS-197 vector, LANES=4: in_data = 193de3bea0f4e22b9ac68d2ae9f84808 → out_data = d42711aee0bf98f1b8b45de51e415230. out_valid rises exactly 4 cycles after the accept edge; busy is high for 4 cycles.
- Uniform inputs:
  - all-0x00 → all-0x63;
  - all-0x53 → all-0xed;
  - all-0xff → all-0x16.
  - Repeat with LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency).
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_valid stays 1, out_data is unchanged, in_ready stays 0. Asserting out_ready retires the block with one handshake only.
- Simultaneous retire and accept: in DONE drive out_ready = 1 and in_valid = 1 with in_data = 000102…0f → same-edge transfer. Next result = 637c777bf26b6fc53001672bfed7ab76 after NCYC cycles; no IDLE cycle in between.
- Reset mid-BUSY: assert rst during cycle 2 of BUSY → next cycle out_valid = 0, out_data = 0, busy = 0. After deassert, in_ready = 1 and a fresh block completes correctly.
- Round trip: pass all 256 byte values (16 per block, 16 blocks) through the block, then through the decryption inverse S-box → original bytes recovered with zero mismatches.
